// File: rtl/sample_main_issue_ctrl.sv
// Two-requester round-robin issue controller for a fixed-latency pipeline,
// with credit-based admission into a first-word-fall-through response FIFO.
module sample_main_issue_ctrl #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    output logic              pipe_input_valid,
    input  logic              pipe_output_valid,
    input  logic [DATA_W-1:0] pipe_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic              err_protocol
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IW = $clog2(LATENCY + 1);
    localparam int unsigned FW = $clog2(LATENCY + 1);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + LATENCY + 1);

    localparam logic [0:0] ST_FLUSH = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state;
    logic [FW-1:0]     flush_cnt;
    logic              flush;
    logic              ptr;
    logic              winner;
    logic              issue;
    logic [IW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic [OW-1:0]     occupancy;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LATENCY-1:0] sh_v;
    logic [LATENCY-1:0] sh_id;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_id   [FIFO_DEPTH];
    logic              pov;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;

    assign flush = (state == ST_FLUSH);

    // Admission uses registered occupancy only, so a pop frees a credit one cycle later.
    always_comb begin
        winner    = (req_valid == 2'b11) ? ptr : req_valid[1];
        occupancy = OW'(fifo_count) + OW'(inflight);
        req_ready = '0;
        if (!flush && (occupancy < OW'(FIFO_DEPTH)) && (req_valid != 2'b00)) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign issue            = |req_ready;
    assign pipe_input_valid = issue;

    // Datapath valids are unreset, so anything emerging during the flush is garbage.
    assign pov   = pipe_output_valid && !flush;
    assign empty = (fifo_count == '0);
    assign full  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop   = !empty && resp_ready;
    assign push  = pov && (!full || pop);

    assign resp_valid = !empty;
    assign resp_data  = empty ? '0   : mem_data[rd_ptr];
    assign resp_id    = empty ? 1'b0 : mem_id[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FLUSH;
            flush_cnt    <= FW'(LATENCY);
            ptr          <= 1'b0;
            inflight     <= '0;
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sh_v         <= '0;
            sh_id        <= '0;
            err_protocol <= 1'b0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    if (flush_cnt <= FW'(1)) begin
                        state     <= ST_RUN;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase

            if (issue) begin
                ptr <= ~winner;
            end

            sh_v[0]  <= issue;
            sh_id[0] <= winner;
            for (int unsigned k = 1; k < LATENCY; k++) begin
                sh_v[k]  <= sh_v[k-1];
                sh_id[k] <= sh_id[k-1];
            end

            if (pov != sh_v[LATENCY-1]) begin
                err_protocol <= 1'b1;
            end

            if (issue && !pov && (inflight != IW'(LATENCY))) begin
                inflight <= inflight + IW'(1);
            end else if (!issue && pov && (inflight != '0)) begin
                inflight <= inflight - IW'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= pipe_out;
            mem_id[wr_ptr]   <= sh_id[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_sample_main_issue_ctrl.sv
// Directed vector bench for sample_main_issue_ctrl with a two-stage datapath model;
// vectors are driven on the falling edge and checked mid-cycle.
module tb_sample_main_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        pipe_input_valid;
    logic        pipe_output_valid;
    logic [31:0] pipe_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic        err_protocol;

    logic        inj;
    logic [31:0] ld;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  rv;
        logic        rr;
        logic        inj;
        logic [31:0] ld;
        logic [1:0]  e_rdy;
        logic        e_vld;
        logic [1:0]  chk;
        logic [31:0] e_data;
        logic        e_id;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    sample_main_issue_ctrl #(
        .LATENCY   (2),
        .FIFO_DEPTH(4),
        .DATA_W    (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .pipe_input_valid (pipe_input_valid),
        .pipe_output_valid(pipe_output_valid),
        .pipe_out         (pipe_out),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_id          (resp_id),
        .err_protocol     (err_protocol)
    );

    // Two-stage datapath model; inj forces an unsolicited result carrying ld.
    logic [1:0]  pv  = '0;
    logic [31:0] dp0 = '0;
    logic [31:0] dp1 = '0;
    always @(posedge clk) begin
        pv  <= {pv[0], pipe_input_valid};
        dp0 <= ld;
        dp1 <= dp0;
    end
    assign pipe_output_valid = pv[1] | inj;
    assign pipe_out          = inj ? ld : dp1;

    function automatic vec_t mk(input logic [1:0] rv, input logic rr, input logic in_j,
                                input logic [31:0] l, input logic [1:0] rdy, input logic vld,
                                input logic [1:0] chk, input logic [31:0] d, input logic id,
                                input logic err);
        vec_t v;
        v.rv = rv; v.rr = rr; v.inj = in_j; v.ld = l;
        v.e_rdy = rdy; v.e_vld = vld; v.chk = chk; v.e_data = d; v.e_id = id; v.e_err = err;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vector %0d %s: got %h expected %h", n_vec, name, act, exp);
        end
    endtask

    // chk[0] enables the data check, chk[1] the id check.
    task automatic apply(input vec_t v);
        req_valid  = v.rv;
        resp_ready = v.rr;
        inj        = v.inj;
        ld         = v.ld;
        #2;
        cmp("req_ready", 32'(req_ready), 32'(v.e_rdy));
        cmp("pipe_input_valid", 32'(pipe_input_valid), 32'(|v.e_rdy));
        cmp("resp_valid", 32'(resp_valid), 32'(v.e_vld));
        if (v.chk[0]) cmp("resp_data", resp_data, v.e_data);
        if (v.chk[1]) cmp("resp_id", 32'(resp_id), 32'(v.e_id));
        cmp("err_protocol", 32'(err_protocol), 32'(v.e_err));
        n_vec++;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        inj        = 1'b0;
        ld         = '0;

        // Steps counted from reset release; first two are the flush window.
        tbl.push_back(mk(2'b01, 1, 0, 32'h0,   2'b00, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b01, 1, 0, 32'h0,   2'b00, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b01, 1, 0, 32'h2a,  2'b01, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 32'h0,   2'b00, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h2a,  0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h2a,  0, 0));
        // Lone requester 1 wins, pointer returns to 0, then alternation.
        tbl.push_back(mk(2'b10, 1, 0, 32'h100, 2'b10, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h200, 2'b01, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h201, 2'b10, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h202, 2'b01, 1, 2'b11, 32'h100, 1, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h203, 2'b10, 1, 2'b11, 32'h200, 0, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h204, 2'b01, 1, 2'b11, 32'h201, 1, 0));
        tbl.push_back(mk(2'b11, 1, 0, 32'h205, 2'b10, 1, 2'b11, 32'h202, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h203, 1, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h204, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h205, 1, 0));
        // Backpressure: four issues fill the credits, then stall.
        tbl.push_back(mk(2'b01, 0, 0, 32'h300, 2'b01, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h301, 2'b01, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h302, 2'b01, 0, 2'b00, 32'h0,   0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h303, 2'b01, 1, 2'b11, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h300, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h304, 2'b01, 1, 2'b11, 32'h301, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h301, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 32'h0,   2'b00, 1, 2'b11, 32'h301, 0, 0));
        // Full FIFO: injected push with simultaneous pop keeps four entries, in order.
        tbl.push_back(mk(2'b00, 1, 1, 32'h5a5, 2'b00, 1, 2'b11, 32'h301, 0, 0));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h302, 0, 1));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h303, 0, 1));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b11, 32'h304, 0, 1));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 1, 2'b01, 32'h5a5, 0, 1));
        tbl.push_back(mk(2'b00, 1, 0, 32'h0,   2'b00, 0, 2'b00, 32'h0,   0, 1));

        @(negedge clk);
        apply(mk(2'b11, 1, 1, 32'h1234, 2'b00, 0, 2'b11, 32'h0, 0, 0));
        apply(mk(2'b01, 0, 0, 32'h0,    2'b00, 0, 2'b11, 32'h0, 0, 0));
        rst_n = 1'b1;
        foreach (tbl[i]) apply(tbl[i]);

        // Sticky error clears only on reset; injection during flush is ignored.
        rst_n = 1'b0;
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b11, 32'h0,  0, 0));
        rst_n = 1'b1;
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 1, 1, 32'h66, 2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 0, 1, 32'h77, 2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 0, 0, 32'h0,  2'b00, 1, 2'b01, 32'h77, 0, 1));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 1, 2'b01, 32'h77, 0, 1));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 1));

        // Reset with results in flight and buffered: nothing stale may surface.
        rst_n = 1'b0;
        apply(mk(2'b00, 0, 0, 32'h0,  2'b00, 0, 2'b11, 32'h0,  0, 0));
        rst_n = 1'b1;
        apply(mk(2'b01, 0, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 0, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 0, 0, 32'he0, 2'b01, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 0, 0, 32'he1, 2'b01, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 0, 0, 32'he2, 2'b01, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 0, 0, 32'he3, 2'b01, 1, 2'b11, 32'he0, 0, 0));
        rst_n = 1'b0;
        apply(mk(2'b01, 0, 0, 32'h0,  2'b00, 0, 2'b11, 32'h0,  0, 0));
        rst_n = 1'b1;
        apply(mk(2'b01, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b01, 1, 0, 32'hf0, 2'b01, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 1, 2'b11, 32'hf0, 0, 0));
        apply(mk(2'b00, 1, 0, 32'h0,  2'b00, 0, 2'b00, 32'h0,  0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
